// File: rtl/microchip_ram64x12_fifo.sv
// First-word-fall-through 64x12 FIFO controller driving a RAM64x12 macro with a
// registered read address and unregistered read data; owns pointers, occupancy and flow control.
module microchip_ram64x12_fifo #(
    parameter int AFULL_LVL  = 60,
    parameter int AEMPTY_LVL = 4
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic [6:0]  level,
    output logic        almost_full,
    output logic        almost_empty,
    output logic        ram_w_en,
    output logic [5:0]  ram_w_addr,
    output logic [11:0] ram_w_data,
    output logic [5:0]  ram_r_addr,
    output logic        ram_r_addr_en,
    output logic        ram_blk_en,
    input  logic [11:0] ram_r_data,
    input  logic        ram_access_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    localparam logic [6:0] AFULL  = 7'(AFULL_LVL);
    localparam logic [6:0] AEMPTY = 7'(AEMPTY_LVL);

    state_t     state, state_next;
    logic [5:0] wr_ptr, rd_ptr, r_addr_q;
    logic [6:0] ram_cnt, level_q;
    logic       full, accept, pop, issue;

    assign full         = (level_q == 7'd64);
    assign in_ready     = !full && !ram_access_busy;
    assign accept       = in_valid && in_ready;
    assign out_valid    = (state == S_HOLD);
    assign pop          = out_valid && out_ready;
    assign level        = level_q;
    assign almost_full  = (level_q >= AFULL);
    assign almost_empty = (level_q <= AEMPTY);

    assign ram_w_en   = accept;
    assign ram_w_addr = wr_ptr;
    assign ram_w_data = in_data;

    // The macro captures R_ADDR on the issue edge; between issues the last address is held.
    assign ram_r_addr_en = issue;
    assign ram_blk_en    = issue;
    assign ram_r_addr    = issue ? rd_ptr : r_addr_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (ram_cnt != 7'd0 && !ram_access_busy) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: state_next = S_HOLD;
            S_HOLD: begin
                if (pop) begin
                    if (ram_cnt != 7'd0 && !ram_access_busy) begin
                        issue      = 1'b1;
                        state_next = S_WAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            r_addr_q <= '0;
            ram_cnt  <= '0;
            level_q  <= '0;
            out_data <= '0;
        end else begin
            state <= state_next;
            if (accept) wr_ptr <= wr_ptr + 6'd1;
            if (issue) begin
                rd_ptr   <= rd_ptr + 6'd1;
                r_addr_q <= rd_ptr;
            end
            case ({accept, issue})
                2'b10:   ram_cnt <= ram_cnt + 7'd1;
                2'b01:   ram_cnt <= ram_cnt - 7'd1;
                default: ram_cnt <= ram_cnt;
            endcase
            case ({accept, pop})
                2'b10:   level_q <= level_q + 7'd1;
                2'b01:   level_q <= level_q - 7'd1;
                default: level_q <= level_q;
            endcase
            // R_DATA is unregistered in the macro, so it is only valid during WAIT.
            if (state == S_WAIT) out_data <= ram_r_data;
        end
    end

endmodule
